seg7_scan_display: RTL and testbench

//  Downstream consumer of the countdown timer's 16-bit BCD MM:SS word.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_decode.sv | 33 +++
 rtl/seg7_scan_display.sv | 165 ++++++++++++++++
 tb/tb_seg7_scan_display.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared constants for the 4-digit 7-segment scan display.
//                Segment patterns are {g,f,e,d,c,b,a}, active low.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Digit glyphs, a '-' for non-BCD codes, and all segments dark
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    // Display mode encoding
    localparam logic [1:0] MODE_IDLE    = 2'd0;
    localparam logic [1:0] MODE_COUNT   = 2'd1;
    localparam logic [1:0] MODE_EXPIRED = 2'd2;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational BCD nibble to active-low 7-segment pattern.
//                Codes 10-15 show a single dash (segment g only).
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Glyph lookup; anything outside 0-9 renders as '-'
    always_comb begin
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_display.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_display
//  Description : Time-multiplexed driver for a common-anode 4-digit display
//                showing a BCD MM:SS word. Blinking colon while counting,
//                whole-display flash at 00:00, leading-zero blanking and
//                per-digit dead time against ghosting.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int DIGIT_TICKS = 100_000,
    parameter int DEAD_TICKS  = 2_000,
    parameter int BLINK_TICKS = 50_000_000,
    parameter int LZB         = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] digits,
    input  logic        run,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_slot;
    logic [BW-1:0] r_blink;
    logic          r_phase;
    logic [15:0]   r_snap;
    logic          r_run_d;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          w_cnt_wrap;
    logic          w_blink_wrap;
    logic          w_run_rise;
    logic [1:0]    w_mode;
    logic [3:0]    w_digit;
    logic [6:0]    w_dec;
    logic [3:0]    w_an_nxt;
    logic [6:0]    w_seg_nxt;
    logic          w_dp_nxt;

    assign w_cnt_wrap   = (r_cnt == CW'(DIGIT_TICKS - 1));
    assign w_blink_wrap = (r_blink == BW'(BLINK_TICKS - 1));
    assign w_run_rise   = run & ~r_run_d;

    // Slot timer: each slot lasts DIGIT_TICKS, slots walk 3,2,1,0 and wrap
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt  <= '0;
            r_slot <= 2'd3;
        end else if (w_cnt_wrap) begin
            r_cnt  <= '0;
            r_slot <= r_slot - 2'd1;
        end else begin
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    // Latch the time once per frame so all four digits come from one value
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_snap <= 16'h0000;
        end else if (w_cnt_wrap && (r_slot == 2'd0)) begin
            r_snap <= digits;
        end
    end

    // Blink phase generator; a fresh run restarts the colon in its lit phase
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_blink <= '0;
            r_phase <= 1'b1;
            r_run_d <= 1'b0;
        end else begin
            r_run_d <= run;
            if (w_run_rise) begin
                r_blink <= '0;
                r_phase <= 1'b1;
            end else if (w_blink_wrap) begin
                r_blink <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_blink <= r_blink + BW'(1);
            end
        end
    end

    // Display mode from the registered run level and the frame snapshot
    always_comb begin
        if (!r_run_d) begin
            w_mode = MODE_IDLE;
        end else if (r_snap != 16'h0000) begin
            w_mode = MODE_COUNT;
        end else begin
            w_mode = MODE_EXPIRED;
        end
    end

    // Pick the nibble for the active slot; seconds tens sits in the low nibble
    always_comb begin
        case (r_slot)
            2'd3:    w_digit = r_snap[15:12];
            2'd2:    w_digit = r_snap[11:8];
            2'd1:    w_digit = r_snap[3:0];
            default: w_digit = r_snap[7:4];
        endcase
    end

    seg7_decode u_decode (
        .i_bcd (w_digit),
        .o_seg (w_dec)
    );

    // Next anode/segment/colon values: dark during dead time, else the slot
    always_comb begin
        w_an_nxt  = 4'b1111;
        w_seg_nxt = SEG_OFF;
        w_dp_nxt  = 1'b1;
        if (r_cnt >= CW'(DEAD_TICKS)) begin
            w_an_nxt  = ~(4'b0001 << r_slot);
            w_seg_nxt = w_dec;
            if ((LZB != 0) && (r_slot == 2'd3) && (w_digit == 4'd0)) begin
                w_seg_nxt = SEG_OFF;
            end
            if (r_slot == 2'd2) begin
                case (w_mode)
                    MODE_IDLE: w_dp_nxt = 1'b0;
                    default:   w_dp_nxt = ~r_phase;
                endcase
            end
            // Expired flash: everything dark in the off phase, anodes keep scanning
            if ((w_mode == MODE_EXPIRED) && !r_phase) begin
                w_seg_nxt = SEG_OFF;
                w_dp_nxt  = 1'b1;
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_an  <= 4'b1111;
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
            r_dp  <= w_dp_nxt;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_display
//  Description : Scoreboard bench for seg7_scan_display. Expected outputs
//                come from a frame/time based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_display;

    localparam int DT = 8;
    localparam int DD = 2;
    localparam int BT = 40;
    localparam int FR = 4 * DT;

    logic        clk    = 1'b0;
    logic        rstn   = 1'b0;
    logic        run    = 1'b0;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } out_t;

    out_t q_exp[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_cyc   = 0;

    // Reference model state: position in the frame, cycles since the blink
    // origin, the frame-latched time and the previous run level
    int          m_pos;
    int          m_age;
    logic [15:0] m_snap;
    logic        m_run_d;

    always #5 clk = ~clk;

    seg7_scan_display #(
        .DIGIT_TICKS (DT),
        .DEAD_TICKS  (DD),
        .BLINK_TICKS (BT),
        .LZB         (1)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .digits (digits),
        .run    (run),
        .an     (an),
        .seg    (seg),
        .dp     (dp)
    );

    // Standard lit-segment masks {g..a}; the display is active low
    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] lit;
        case (v)
            4'd0: lit = 7'h3F;
            4'd1: lit = 7'h06;
            4'd2: lit = 7'h5B;
            4'd3: lit = 7'h4F;
            4'd4: lit = 7'h66;
            4'd5: lit = 7'h6D;
            4'd6: lit = 7'h7D;
            4'd7: lit = 7'h07;
            4'd8: lit = 7'h7F;
            4'd9: lit = 7'h6F;
            default: lit = 7'h40;
        endcase
        return ~lit;
    endfunction

    function automatic out_t expect_now();
        out_t       e;
        int         slot;
        int         inslot;
        logic [3:0] d;
        bit         phase_on;
        bit         expired;
        e.an   = 4'b1111;
        e.seg  = 7'h7F;
        e.dp   = 1'b1;
        slot   = 3 - (m_pos / DT);
        inslot = m_pos % DT;
        if (inslot < DD) return e;
        case (slot)
            3:       d = m_snap[15:12];
            2:       d = m_snap[11:8];
            1:       d = m_snap[3:0];
            default: d = m_snap[7:4];
        endcase
        phase_on = ((m_age / BT) % 2) == 0;
        expired  = m_run_d && (m_snap == 16'h0000);
        e.an[slot] = 1'b0;
        e.seg = glyph(d);
        if (slot == 3 && d == 4'd0) e.seg = 7'h7F;
        if (slot == 2) e.dp = m_run_d ? !phase_on : 1'b0;
        if (expired && !phase_on) begin
            e.seg = 7'h7F;
            e.dp  = 1'b1;
        end
        return e;
    endfunction

    // Predict the response to the inputs now applied, then advance the model
    task automatic step();
        out_t e;
        if (!rstn) begin
            e.an    = 4'b1111;
            e.seg   = 7'h7F;
            e.dp    = 1'b1;
            m_pos   = 0;
            m_age   = 0;
            m_snap  = 16'h0000;
            m_run_d = 1'b0;
        end else begin
            e = expect_now();
            if (m_pos == FR - 1) m_snap = digits;
            m_pos = (m_pos + 1) % FR;
            if (run && !m_run_d) m_age = 0;
            else                 m_age = m_age + 1;
            m_run_d = run;
        end
        q_exp.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic ru, input logic [15:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rstn   = r;
            run    = ru;
            digits = d;
            step();
        end
    endtask

    function automatic logic [15:0] rand_digits();
        logic [3:0] mt, mu, st, su;
        int kind;
        kind = $urandom_range(0, 3);
        mt = 4'($urandom_range(0, 5));
        mu = 4'($urandom_range(0, 9));
        st = 4'($urandom_range(0, 5));
        su = 4'($urandom_range(0, 9));
        case (kind)
            0:       return 16'h0000;
            1:       return {4'h0, mu, su, st};
            2:       return 16'($urandom);
            default: return {mt, mu, su, st};
        endcase
    endfunction

    // Monitor: one registered output word per clock, checked in order
    initial begin
        out_t e;
        forever begin
            @(posedge clk);
            #1;
            n_cyc++;
            n_tests++;
            if (q_exp.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard cycle %0d: output an=%b seg=%h dp=%b with no expectation queued",
                         n_cyc, an, seg, dp);
            end else begin
                e = q_exp.pop_front();
                if ({an, seg, dp} !== e) begin
                    n_fail++;
                    $display("FAIL scan cycle %0d: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                             n_cyc, an, seg, dp, e.an, e.seg, e.dp);
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic        r_run;
        logic [15:0] r_dig;
        rstn = 1'b0; run = 1'b0; digits = 16'h0000;
        step();
        cyc(1'b0, 1'b0, 16'h0000, 2);                 // reset held 3 clocks
        cyc(1'b1, 1'b0, 16'h0000, 12);                // first dark/active slots
        cyc(1'b1, 1'b0, 16'h0593, 60);                // plain scan, idle colon
        cyc(1'b1, 1'b0, 16'h1234, 70);                // changed mid-frame
        cyc(1'b1, 1'b1, 16'h0010, 200);               // colon blink
        cyc(1'b1, 1'b1, 16'h0000, 220);               // expiry flash
        cyc(1'b1, 1'b0, 16'h0000, 25);                // run falls: idle at once
        cyc(1'b1, 1'b1, 16'h0000, 90);                // run rises again
        cyc(1'b1, 1'b1, 16'hF000, 75);                // invalid BCD in min tens
        cyc(1'b0, 1'b1, 16'hF000, 2);                 // reset mid-frame
        cyc(1'b1, 1'b1, 16'hF000, 40);
        r_run = 1'b0;
        r_dig = 16'h0000;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) r_run = ~r_run;
            if ($urandom_range(0, 19) == 0) r_dig = rand_digits();
            if ($urandom_range(0, 299) == 0) cyc(1'b0, r_run, r_dig, 1);
            else                             cyc(1'b1, r_run, r_dig, 1);
        end
        @(posedge clk);
        #2;
        n_tests++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q_exp.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
